// File: rtl/bicubic_pad_sequencer.sv
// bicubic_pad_sequencer
//   Wraps an unpadded WIDTH x HEIGHT RGB raster in the zero border that the
//   bicubic 4x4 window needs. The border is one row on top, one column on the
//   left, two columns on the right and two rows at the bottom. The output is a
//   (WIDTH+3) x (HEIGHT+3) stream with sof/eol/eof markers.
// Ports
//   clk, rst        clock, async active-high reset
//   en              frame start request, sampled only in IDLE
//   s_data/s_valid/s_ready   source pixel stream
//   m_data/m_valid/m_ready   padded pixel stream (single register stage)
//   m_sof/m_eol/m_eof        boundary flags registered alongside m_data
//   busy            frame in progress or output beat still pending
//   frame_done      one-cycle pulse after the eof beat handshakes
module bicubic_pad_sequencer #(
  parameter int WIDTH  = 960,
  parameter int HEIGHT = 540,
  parameter int DW     = 24
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [DW-1:0] s_data,
  input  logic          s_valid,
  output logic          s_ready,
  output logic [DW-1:0] m_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic          m_sof,
  output logic          m_eol,
  output logic          m_eof,
  output logic          busy,
  output logic          frame_done
);

  localparam int CW = $clog2(WIDTH + 3);
  localparam int RW = $clog2(HEIGHT + 3);

  localparam logic [CW-1:0] COL_PIX_LAST = CW'(WIDTH);
  localparam logic [CW-1:0] COL_LAST     = CW'(WIDTH + 2);
  localparam logic [RW-1:0] ROW_SRC_LAST = RW'(HEIGHT);
  localparam logic [RW-1:0] ROW_LAST     = RW'(HEIGHT + 2);

  typedef enum logic [2:0] {IDLE, TOP, LEFT, PIX, RIGHT, BOTTOM} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          out_free, beat_avail, load, col_wrap;

  // Next-state and handshake decode
  always_comb begin
    out_free   = ~m_valid | m_ready;
    beat_avail = (state == PIX) ? s_valid : (state != IDLE);
    load       = out_free & beat_avail;
    s_ready    = (state == PIX) & out_free;
    col_wrap   = (col == COL_LAST);
    state_nxt  = state;
    unique case (state)
      IDLE:   if (en) state_nxt = TOP;
      TOP:    if (load && col_wrap) state_nxt = LEFT;
      LEFT:   if (load) state_nxt = PIX;
      PIX:    if (load && col == COL_PIX_LAST) state_nxt = RIGHT;
      RIGHT:  if (load && col_wrap)
                state_nxt = (row == ROW_SRC_LAST) ? BOTTOM : LEFT;
      BOTTOM: if (load && col_wrap && row == ROW_LAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Padded position of the next beat to load
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (state == IDLE) begin
      if (en) begin
        col <= '0;
        row <= '0;
      end
    end else if (load) begin
      if (col_wrap) begin
        col <= '0;
        // Wrapping row after the last padded row keeps it in range for any HEIGHT
        row <= (row == ROW_LAST) ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  // Output register: data and flags move together and hold under backpressure
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid    <= 1'b0;
      m_data     <= '0;
      m_sof      <= 1'b0;
      m_eol      <= 1'b0;
      m_eof      <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= m_valid & m_ready & m_eof;
      if (load) begin
        m_valid <= 1'b1;
        m_data  <= (state == PIX) ? s_data : '0;
        m_sof   <= (row == '0) && (col == '0);
        m_eol   <= col_wrap;
        m_eof   <= col_wrap && (row == ROW_LAST);
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

  assign busy = (state != IDLE) | m_valid;

endmodule

// File: tb/tb_bicubic_pad_sequencer.sv
module tb_bicubic_pad_sequencer;

  localparam int W     = 4;
  localparam int H     = 2;
  localparam int DW    = 24;
  localparam int PW    = W + 3;
  localparam int FRAME = (W + 3) * (H + 3);

  logic          clk = 1'b0;
  logic          rst, en, s_valid, s_ready, m_valid, m_ready;
  logic          m_sof, m_eol, m_eof, busy, frame_done;
  logic [DW-1:0] s_data, m_data;

  bicubic_pad_sequencer #(.WIDTH(W), .HEIGHT(H), .DW(DW)) dut (
    .clk(clk), .rst(rst), .en(en),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_sof(m_sof), .m_eol(m_eol), .m_eof(m_eof),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0;
  int drv_idx = 0, exp_base = 0, exp_bi = 0;
  int frames_done = 0, beats = 0, eols = 0, cyc = 0;
  int eof_cyc = -1000, last_gap = 0;
  bit exp_done = 0, rnd = 0;
  bit prev_stall = 0;
  logic [DW+2:0] prev_out;
  logic [DW-1:0] obs_data [FRAME];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] pix_val(input int i);
    return DW'(i + 1);
  endfunction

  // Reference: padded frame beat bi given the source pixel index of its first pixel
  function automatic logic [DW+2:0] model(input int base, input int bi);
    int r, c;
    logic [DW-1:0] d;
    r = bi / PW;
    c = bi % PW;
    d = (r >= 1 && r <= H && c >= 1 && c <= W) ? pix_val(base + (r - 1) * W + (c - 1)) : '0;
    return {d, bi == 0, c == PW - 1, bi == FRAME - 1};
  endfunction

  // Compare process: outputs sampled mid-cycle, handshakes decided for the next edge
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      chk("rst_ctrl", {m_valid, m_sof, m_eol, m_eof, frame_done, busy, s_ready}, 0);
      chk("rst_data", m_data, 0);
      prev_stall = 0;
      exp_done = 0;
    end else begin
      chk("frame_done", frame_done, exp_done);
      exp_done = 0;
      if (m_valid) chk("busy", busy, 1);
      if (prev_stall) chk("hold", {m_valid, m_data, m_sof, m_eol, m_eof}, {1'b1, prev_out});
      if (m_valid && !m_ready) chk("s_ready_stall", s_ready, 0);
      if (s_valid && s_ready) drv_idx++;
      if (m_valid && m_ready) begin
        chk("beat", {m_data, m_sof, m_eol, m_eof}, model(exp_base, exp_bi));
        obs_data[exp_bi] = m_data;
        if (m_eol) eols++;
        if (m_sof) last_gap = cyc - eof_cyc;
        if (m_eof) eof_cyc = cyc;
        beats++;
        exp_bi++;
        if (exp_bi == FRAME) begin
          exp_bi = 0;
          exp_base += W * H;
          frames_done++;
          exp_done = 1;
        end
      end
      prev_stall = m_valid && !m_ready;
      prev_out = {m_data, m_sof, m_eol, m_eof};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd) begin
      s_valid = ($urandom_range(0, 99) < 70);
      m_ready = ($urandom_range(0, 99) < 50);
    end
    s_data = pix_val(drv_idx);
  endtask

  task automatic run_frames(input int n);
    int target, k;
    target = frames_done + n;
    k = 0;
    while (frames_done < target && k < 3000) begin
      tick();
      k++;
    end
    chk("frame_timeout", frames_done, target);
  endtask

  initial begin
    int b0, f0, k;
    // Reset with inputs active
    rst = 1; en = 1; s_valid = 1; m_ready = 1; s_data = pix_val(0);
    repeat (3) tick();
    rst = 0; en = 0;
    repeat (20) tick();
    chk("idle_beats", beats, 0);
    chk("idle_valid", m_valid, 0);

    // Small frame, full throughput, first-beat latency pinned
    eols = 0;
    en = 1;
    tick();
    en = 0;
    chk("first_lat0", m_valid, 0);
    tick();
    chk("first_lat1", {m_valid, m_sof}, 2'b11);
    run_frames(1);
    chk("f1_beats", beats, 35);
    chk("f1_eols", eols, 5);
    chk("pin_r1c1", obs_data[8], 1);
    chk("pin_r1c4", obs_data[11], 4);
    chk("pin_r1c5", obs_data[12], 0);
    chk("pin_r2c1", obs_data[15], 5);
    chk("pin_r2c4", obs_data[18], 8);
    chk("pin_last", obs_data[34], 0);

    // Random backpressure and starvation
    rnd = 1;
    en = 1;
    tick();
    en = 0;
    run_frames(1);
    rnd = 0; s_valid = 1; m_ready = 1;
    repeat (3) tick();
    chk("rnd_pix", drv_idx, 16);

    // Back-to-back frames with en held high
    b0 = beats;
    f0 = frames_done;
    en = 1;
    k = 0;
    while (frames_done < f0 + 2 && k < 3000) begin
      tick();
      if (frames_done >= f0 + 1) en = 0;
      k++;
    end
    chk("b2b_frames", frames_done, f0 + 2);
    chk("b2b_beats", beats - b0, 70);
    chk("b2b_gap", last_gap, 2);
    repeat (5) tick();

    // Reset mid-frame, then restart
    en = 1;
    tick();
    en = 0;
    k = 0;
    while (exp_bi < 17 && k < 500) begin
      tick();
      k++;
    end
    chk("abort_reach", exp_bi, 17);
    rst = 1;
    exp_bi = 0;
    exp_base = drv_idx;
    f0 = frames_done;
    repeat (2) tick();
    rst = 0;
    chk("abort_nodone", frames_done, f0);
    en = 1;
    tick();
    en = 0;
    run_frames(1);

    // en pulsed for one cycle: one frame, then quiet
    rnd = 1;
    b0 = beats;
    en = 1;
    tick();
    en = 0;
    run_frames(1);
    rnd = 0; m_ready = 1; s_valid = 1;
    repeat (10) tick();
    chk("pulse_beats", beats - b0, 35);
    chk("pulse_busy", busy, 0);
    chk("pulse_valid", m_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
